// File: rtl/microwave_pkg.sv
// Shared types and helpers for the microwave controller: keypad width,
// BCD digit type, keypad-entry FSM states and one-hot helpers.
package microwave_pkg;

  localparam int KEYS = 10;
  localparam int DEBOUNCE_CYCLES_DEF = 3;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    ACCEPT       = 2'd2,
    WAIT_RELEASE = 2'd3
  } entry_state_t;

  function automatic logic is_onehot(input logic [KEYS-1:0] p);
    return (p != {KEYS{1'b0}}) && ((p & (p - KEYS'(1))) == {KEYS{1'b0}});
  endfunction

  // Non-one-hot patterns never reach the encoder; they fall to zero.
  function automatic bcd_t onehot_to_bcd(input logic [KEYS-1:0] p);
    bcd_t r;
    case (p)
      10'b0000000001: r = 4'd0;
      10'b0000000010: r = 4'd1;
      10'b0000000100: r = 4'd2;
      10'b0000001000: r = 4'd3;
      10'b0000010000: r = 4'd4;
      10'b0000100000: r = 4'd5;
      10'b0001000000: r = 4'd6;
      10'b0010000000: r = 4'd7;
      10'b0100000000: r = 4'd8;
      10'b1000000000: r = 4'd9;
      default:        r = 4'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/keypad_debouncer.sv
// Synchronizes the raw keypad, debounces presses and releases, and emits a
// one-cycle accept pulse (with the held pattern) or an error pulse.
module keypad_debouncer
  import microwave_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [KEYS-1:0] keypad,
  output logic            accept,
  output logic [KEYS-1:0] pattern,
  output logic            error
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [KEYS-1:0]  NO_KEY   = {KEYS{1'b0}};

  logic [KEYS-1:0] sync1_r, ksync_r, pattern_r, pattern_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  entry_state_t     state_r, state_s;
  logic             error_r, error_s, accept_r;

  // two-flop synchronizer for the asynchronous keypad
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_r <= NO_KEY;
      ksync_r <= NO_KEY;
    end else begin
      sync1_r <= keypad;
      ksync_r <= sync1_r;
    end
  end

  // next-state logic; a full count wins so N identical samples always decide
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    pattern_s = pattern_r;
    error_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (ksync_r != NO_KEY) begin
          pattern_s = ksync_r;
          cnt_s     = CNT_ONE;
          state_s   = DEBOUNCE;
        end else begin
          state_s = IDLE;
        end
      end
      DEBOUNCE: begin
        if (cnt_r == CNT_MAX) begin
          cnt_s = CNT_ZERO;
          if (is_onehot(pattern_r)) begin
            state_s = ACCEPT;
          end else begin
            error_s = 1'b1;
            state_s = WAIT_RELEASE;
          end
        end else if (ksync_r == NO_KEY) begin
          cnt_s   = CNT_ZERO;
          state_s = IDLE;
        end else if (ksync_r != pattern_r) begin
          pattern_s = ksync_r;
          cnt_s     = CNT_ONE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ACCEPT: begin
        cnt_s   = CNT_ZERO;
        state_s = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (cnt_r == CNT_MAX) begin
          cnt_s   = CNT_ZERO;
          state_s = IDLE;
        end else if (ksync_r == NO_KEY) begin
          cnt_s = cnt_r + CNT_ONE;
        end else begin
          cnt_s = CNT_ZERO;
        end
      end
      default: begin
        cnt_s   = CNT_ZERO;
        state_s = IDLE;
      end
    endcase
  end

  // FSM, counter, captured pattern and registered pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      pattern_r <= NO_KEY;
      error_r   <= 1'b0;
      accept_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      pattern_r <= pattern_s;
      error_r   <= error_s;
      accept_r  <= (state_s == ACCEPT);
    end
  end

  assign accept  = accept_r;
  assign pattern = pattern_r;
  assign error   = error_r;

endmodule

// File: rtl/keypad_entry.sv
// Keypad front-end: debounced digits shift right-to-left into the
// min : sec_tens : sec_ones time-entry register.
module keypad_entry
  import microwave_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [KEYS-1:0] keypad,
  input  logic            clearn,
  input  logic            load_en,
  output logic [3:0]      min_bcd,
  output logic [3:0]      sec_tens_bcd,
  output logic [3:0]      sec_ones_bcd,
  output logic            digit_valid,
  output logic            key_error,
  output logic            entry_nonzero
);

  logic            accept_s;
  logic            error_s;
  logic [KEYS-1:0] pattern_s;
  logic            shift_s;
  bcd_t            min_s, tens_s, ones_s;

  keypad_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debouncer (
    .clock  (clock),
    .reset  (reset),
    .keypad (keypad),
    .accept (accept_s),
    .pattern(pattern_s),
    .error  (error_s)
  );

  // next entry-register value; clear overrides a coincident shift
  always_comb begin
    shift_s = accept_s & load_en & clearn;
    if (!clearn) begin
      min_s  = 4'd0;
      tens_s = 4'd0;
      ones_s = 4'd0;
    end else if (shift_s) begin
      min_s  = sec_tens_bcd;
      tens_s = sec_ones_bcd;
      ones_s = onehot_to_bcd(pattern_s);
    end else begin
      min_s  = min_bcd;
      tens_s = sec_tens_bcd;
      ones_s = sec_ones_bcd;
    end
  end

  // entry register and registered status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      min_bcd       <= 4'd0;
      sec_tens_bcd  <= 4'd0;
      sec_ones_bcd  <= 4'd0;
      digit_valid   <= 1'b0;
      entry_nonzero <= 1'b0;
    end else begin
      min_bcd       <= min_s;
      sec_tens_bcd  <= tens_s;
      sec_ones_bcd  <= ones_s;
      digit_valid   <= shift_s;
      entry_nonzero <= ((min_s | tens_s | ones_s) != 4'd0);
    end
  end

  assign key_error = error_s;

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Upstream front-end of the microwave controller. Converts the raw 10-bit one-hot keypad into debounced BCD digit entries.
- Shifts accepted digits right-to-left into a three-digit time-entry register (min : sec_tens : sec_ones).
- The countdown/magnetron controller loads this register when cooking starts and drives the seven-segment displays from it while idle.
- Runs at the 100 Hz system clock (10 ms period).

Parameters:
- DEBOUNCE_CYCLES, 3, consecutive identical synchronized samples required to accept a press, and consecutive all-zero samples required to accept a release.
- CNT_W, 4, width of the debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  synchronous active-high reset.
- keypad  input  10  raw keys, asynchronous; bit i high = digit i pressed.
- clearn  input  1  active-low clear of the entry register; synchronous to clock.
- load_en  input  1  high when the controller accepts entry (not cooking). Low = accepted presses are discarded.
- min_bcd  output  4  minutes digit.
- sec_tens_bcd  output  4  seconds-tens digit.
- sec_ones_bcd  output  4  seconds-ones digit.
- digit_valid  output  1  one-cycle pulse when a digit is shifted in.
- key_error  output  1  one-cycle pulse when a debounced pattern is not one-hot.
- entry_nonzero  output  1  high when any entry digit is nonzero; used by the controller to gate start.

Behaviour:
- Reset (sync, active-high):
  - Synchronizer flops, captured pattern and counter = 0; FSM = IDLE.
  - All three digits = 0; digit_valid = key_error = 0; entry_nonzero = 0.
- Input sync: keypad passes through a 2-flop synchronizer. FSM sees ksync. Latency is 2 edges.
- FSM states: IDLE, DEBOUNCE, ACCEPT, WAIT_RELEASE.
  - IDLE:
    - ksync = 0: stay.
    - ksync ≠ 0: capture pattern, cnt = 1, go to DEBOUNCE.
  - DEBOUNCE:
    - ksync = 0: go to IDLE (glitch rejected).
    - ksync ≠ 0 and ≠ captured: recapture, cnt = 1.
    - ksync = captured and cnt < N: cnt++.
    - cnt == N and pattern is one-hot: go to ACCEPT.
    - cnt == N and pattern is not one-hot: pulse key_error, go to WAIT_RELEASE.
  - ACCEPT (exactly 1 cycle):
    - load_en = 1 and clearn = 1: min ← sec_tens, sec_tens ← sec_ones, sec_ones ← encoded digit (old min discarded), pulse digit_valid.
    - Otherwise: no shift, no pulse.
    - Always go to WAIT_RELEASE.
  - WAIT_RELEASE:
    - cnt counts consecutive ksync = 0 cycles; any nonzero sample resets cnt to 0.
    - cnt == N: go to IDLE.
    - A held or changed key is never re-accepted without a full release.
- Timing: edge 0 is the first edge sampling the key.
  - DEBOUNCE entered at edge 2; cnt reaches N at edge N+1; ACCEPT at edge N+2.
  - Digit update and digit_valid at edge N+3 (edge 6 for N=3).
  - A press must be held ≥ N cycles to be accepted.
- Encoding: one-hot bit i → BCD i (0–9). Digits are stored raw, with no range check; sec_tens of 6–9 is legal here and is normalized by the controller.
- clearn low: all digits ← 0 on the next edge. Clear wins over a simultaneous ACCEPT shift. clearn does not affect the FSM or synchronizer.
- entry_nonzero: registered; equals (min|sec_tens|sec_ones) ≠ 0 after each update.
- Outputs are registered and glitch-free. digit_valid and key_error are never asserted in the same cycle.
- Reset mid-press: FSM returns to IDLE. A key still held after reset is treated as a new press and is accepted after full debounce.

Decomposition:
- Package microwave_pkg holds:
  - entry_state_t enum (IDLE/DEBOUNCE/ACCEPT/WAIT_RELEASE);
  - bcd_t (4-bit) typedef;
  - KEYS = 10;
  - default DEBOUNCE_CYCLES.
  - The countdown controller shares bcd_t and KEYS.
- Sub-module keypad_debouncer contains the synchronizer, the FSM and the counter. It outputs a one-cycle accept pulse with a 10-bit pattern, plus an error pulse.
- The top level holds the one-hot→BCD encoder, the shift register, clear and entry_nonzero.

Test Plan:
- Reset then keypad=10'b0000001000 held 5 cycles → digit_valid 1 cycle at edge 6; digits 0:0:3; entry_nonzero=1.
- Press 3 (5 cycles), release 15, press 0 (5 cycles), release 15, press 5 → digits 3:0:5, then 0:5 after a further press 0 → 0:5:0. Three/four digit_valid pulses total, old min discarded.
- keypad=10'b0000000101 held 5 cycles → key_error 1 pulse; digits unchanged; no digit_valid.
- 2-cycle glitch on key 7 → no pulse, FSM back to IDLE, digits unchanged. Key 7 held 40 cycles → exactly one digit_valid.
- clearn=0 in the same cycle as ACCEPT of key 9 → digits 0:0:0, no digit_valid, entry_nonzero=0. load_en=0 during press of 4 → no change.
- Assert reset while key held in DEBOUNCE → all outputs 0. Keep key held after reset release → accepted exactly once, N+3 edges after reset drops.
